// File: rtl/shift_issue.sv
// rtl/shift_issue.sv - MIPS shift-instruction issue stage: decodes, drives an external shifter, holds the result.
module shift_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic        rot,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] sh_data,
  output logic [1:0]  sh_op,
  output logic [4:0]  sh_amount,
  input  logic [31:0] sh_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_illegal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        sh_illegal;
  logic [1:0]  dec_op;
  logic [4:0]  dec_amount;
  logic        dec_illegal;
  logic        unused_rs;

  assign unused_rs = ^rs_data[31:5];

  always_comb begin
    dec_op      = OP_SLL;
    dec_amount  = 5'd0;
    dec_illegal = 1'b1;
    case (funct)
      6'b000000: begin dec_op = OP_SLL;                dec_amount = shamt;        dec_illegal = 1'b0; end
      6'b000010: begin dec_op = rot ? OP_ROR : OP_SRL; dec_amount = shamt;        dec_illegal = 1'b0; end
      6'b000011: begin dec_op = OP_SRA;                dec_amount = shamt;        dec_illegal = 1'b0; end
      6'b000100: begin dec_op = OP_SLL;                dec_amount = rs_data[4:0]; dec_illegal = 1'b0; end
      6'b000110: begin dec_op = rot ? OP_ROR : OP_SRL; dec_amount = rs_data[4:0]; dec_illegal = 1'b0; end
      6'b000111: begin dec_op = OP_SRA;                dec_amount = rs_data[4:0]; dec_illegal = 1'b0; end
      default:   begin dec_op = OP_SLL;                dec_amount = 5'd0;         dec_illegal = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  assign accept = in_valid && in_ready;

  // sh_* come straight from registers, so handshake inputs never reach the shifter combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_data     <= 32'd0;
      sh_op       <= OP_SLL;
      sh_amount   <= 5'd0;
      sh_illegal  <= 1'b0;
      out_result  <= 32'd0;
      out_illegal <= 1'b0;
    end else begin
      if (accept) begin
        sh_data    <= rt_data;
        sh_op      <= dec_op;
        sh_amount  <= dec_amount;
        sh_illegal <= dec_illegal;
      end
      if (state == SHIFT) begin
        out_result  <= sh_illegal ? 32'd0 : sh_result;
        out_illegal <= sh_illegal;
      end
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// tb/tb_shift_issue.sv - randomized self-checking bench for shift_issue with a behavioural shifter and model.
module tb_shift_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  funct;
  logic        rot;
  logic [4:0]  shamt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] sh_data;
  logic [1:0]  sh_op;
  logic [4:0]  sh_amount;
  logic [31:0] sh_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_data;
  logic [1:0]  last_op;
  logic [4:0]  last_amt;

  logic [5:0] legal_f [6] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};

  always #5 clk = ~clk;

  shift_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .rot(rot), .shamt(shamt), .rs_data(rs_data), .rt_data(rt_data),
    .sh_data(sh_data), .sh_op(sh_op), .sh_amount(sh_amount), .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_illegal(out_illegal)
  );

  // downstream shifter
  always_comb begin
    case (sh_op)
      2'b00:   sh_result = sh_data << sh_amount;
      2'b01:   sh_result = sh_data >> sh_amount;
      2'b10:   sh_result = $unsigned($signed(sh_data) >>> sh_amount);
      default: sh_result = (sh_amount == 5'd0) ? sh_data
                           : ((sh_data >> sh_amount) | (sh_data << (6'd32 - {1'b0, sh_amount})));
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [5:0] f, input logic r, input logic [4:0] sa,
                       input logic [31:0] rs, input logic [31:0] rt,
                       output logic [1:0] op, output logic [4:0] amt,
                       output logic [31:0] res, output logic ill);
    logic [63:0] dbl;
    ill = 1'b0;
    case (f)
      6'd0:    begin op = 2'd0;             amt = sa;      end
      6'd2:    begin op = r ? 2'd3 : 2'd1;  amt = sa;      end
      6'd3:    begin op = 2'd2;             amt = sa;      end
      6'd4:    begin op = 2'd0;             amt = rs[4:0]; end
      6'd6:    begin op = r ? 2'd3 : 2'd1;  amt = rs[4:0]; end
      6'd7:    begin op = 2'd2;             amt = rs[4:0]; end
      default: begin op = 2'd0;             amt = 5'd0;    ill = 1'b1; end
    endcase
    dbl = {rt, rt} >> amt;
    case (op)
      2'd0:    res = rt << amt;
      2'd1:    res = rt >> amt;
      2'd2:    res = $unsigned($signed(rt) >>> amt);
      default: res = dbl[31:0];
    endcase
    if (ill) res = 32'd0;
  endtask

  // Entered just after a negedge with in_ready expected high; leaves the DUT in DONE with out_ready=1.
  task automatic run_op(input logic [5:0] f, input logic r, input logic [4:0] sa,
                        input logic [31:0] rs, input logic [31:0] rt, input int stall);
    logic [1:0]  e_op;
    logic [4:0]  e_amt;
    logic [31:0] e_res;
    logic        e_ill;
    model(f, r, sa, rs, rt, e_op, e_amt, e_res, e_ill);
    #1;
    check("in_ready_accept", in_ready, 1);
    in_valid = 1'b1; funct = f; rot = r; shamt = sa; rs_data = rs; rt_data = rt;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; funct = $urandom; rot = $urandom; shamt = $urandom;
    rs_data = $urandom; rt_data = $urandom;
    out_ready = (stall == 0);
    #1;
    check("shift_in_ready", in_ready, 0);
    check("shift_out_valid", out_valid, 0);
    check("sh_op", sh_op, e_op);
    check("sh_amount", sh_amount, e_amt);
    check("sh_data", sh_data, rt);
    @(posedge clk); @(negedge clk);
    check("done_out_valid", out_valid, 1);
    check("out_result", out_result, e_res);
    check("out_illegal", out_illegal, e_ill);
    for (int i = 0; i < stall; i++) begin
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_result", out_result, e_res);
      check("stall_out_illegal", out_illegal, e_ill);
      check("stall_sh_data", sh_data, rt);
      check("stall_sh_op", sh_op, e_op);
    end
    out_ready = 1'b1;
    #1;
    check("done_in_ready", in_ready, 1);
    last_data = rt; last_op = e_op; last_amt = e_amt;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_sh_data", sh_data, last_data);
    check("idle_sh_op", sh_op, last_op);
    check("idle_sh_amount", sh_amount, last_amt);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_result"}, out_result, 0);
    check({tag, "_out_illegal"}, out_illegal, 0);
    check({tag, "_sh_data"}, sh_data, 0);
    check({tag, "_sh_op"}, sh_op, 0);
    check({tag, "_sh_amount"}, sh_amount, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [5:0] f;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    funct = 6'd0; rot = 1'b0; shamt = 5'd0; rs_data = 32'd0; rt_data = 32'd0;
    last_data = 32'd0; last_op = 2'd0; last_amt = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_cleared("reset");

    run_op(6'b000000, 1'b0, 5'd4, 32'd0, 32'h0000_0001, 0);
    run_op(6'b000111, 1'b1, 5'd9, 32'h0000_0024, 32'h8000_0000, 0);
    run_op(6'b000010, 1'b1, 5'd4, 32'd0, 32'h0000_00F1, 0);
    run_op(6'b000010, 1'b0, 5'd4, 32'd0, 32'h0000_00F1, 0);
    run_op(6'b100000, 1'b0, 5'd3, 32'd7, 32'h1234_5678, 0);
    run_op(6'b000011, 1'b0, 5'd31, 32'd0, 32'h8000_0000, 5);
    run_op(6'b000110, 1'b1, 5'd0, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 0);
    idle_cycle();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else f = legal_f[$urandom_range(0, 5)];
      run_op(f, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // reset while the instruction is in SHIFT
    #1;
    in_valid = 1'b1; funct = 6'd0; rot = 1'b0; shamt = 5'd5; rt_data = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check_cleared("rst_shift");
    @(posedge clk); @(negedge clk);
    check("rst_shift_discard", out_valid, 0);
    last_data = 32'd0; last_op = 2'd0; last_amt = 5'd0;

    // reset while a result is held in DONE
    run_op(6'b000100, 1'b0, 5'd0, 32'd3, 32'h0000_0101, 0);
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    check_cleared("rst_done");
    last_data = 32'd0; last_op = 2'd0; last_amt = 5'd0;
    run_op(6'b000011, 1'b1, 5'd2, 32'd0, 32'hF000_0000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
